// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART transmit buffer.
package uart_pkg;

  localparam int UART_BYTE_W         = 8;
  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_SEND_CYCLES = 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_RISE = 2'd2;
  localparam logic [1:0] S_WAIT_FALL = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = S_IDLE,
    SEND      = S_SEND,
    WAIT_RISE = S_WAIT_RISE,
    WAIT_FALL = S_WAIT_FALL
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage and a separate occupancy counter.
// Latency: a pushed word is visible on pop_dat one clock later. Backpressure: push ignored when full unless popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue plus launch FSM pacing tx_send on tx_busy; UART_TX_BUFFER_TIMEOUT_EN adds a busy-rise timeout with one retry.
// Latency: 2 clocks from a push into an empty queue to tx_send. Backpressure: none upstream; writes to a full queue drop and set overflow.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int SEND_CYCLES  = DEFAULT_SEND_CYCLES,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   clr_ovf,
  input  logic                   tx_busy,
  output logic                   tx_send,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   active
`ifdef UART_TX_BUFFER_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int SCW = (SEND_CYCLES > 1) ? $clog2(SEND_CYCLES) : 1;

  tx_state_t              state_q, state_d;
  logic [SCW-1:0]         send_cnt_q, send_cnt_d;
  logic                   pop;
  logic                   drop;
  logic [UART_BYTE_W-1:0] head;

`ifdef UART_TX_BUFFER_TIMEOUT_EN
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          retry_q, retry_d;
  logic          tmo_fail;
`endif

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .push_dat (wr_data),
    .pop      (pop),
    .pop_dat  (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign drop    = wr_en && full && !pop;
  assign tx_send = (state_q == SEND);
  assign active  = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    send_cnt_d = send_cnt_q;
    pop        = 1'b0;
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    tmo_d      = tmo_q;
    retry_d    = retry_q;
    tmo_fail   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_d    = SEND;
          send_cnt_d = SCW'(SEND_CYCLES - 1);
`ifdef UART_TX_BUFFER_TIMEOUT_EN
          retry_d    = 1'b0;
`endif
        end
      end
      SEND: begin
`ifdef UART_TX_BUFFER_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (send_cnt_q == '0) state_d = WAIT_RISE;
        else                  send_cnt_d = send_cnt_q - SCW'(1);
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_d = WAIT_FALL;
        end
`ifdef UART_TX_BUFFER_TIMEOUT_EN
        // One re-launch of the same byte, then give up and discard it.
        else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          if (!retry_q) begin
            retry_d    = 1'b1;
            state_d    = SEND;
            send_cnt_d = SCW'(SEND_CYCLES - 1);
          end else begin
            tmo_fail = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      WAIT_FALL: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      send_cnt_q <= '0;
      tx_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_cnt_q <= send_cnt_d;
      if (pop) tx_data <= head;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

`ifdef UART_TX_BUFFER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q       <= '0;
      retry_q     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      if (tmo_fail)     timeout_err <= 1'b1;
      else if (clr_ovf) timeout_err <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Byte FIFO plus launch FSM between the PCH peripheral decoder and the UART transmitter of UART_TxRx.
- The CPU writes bytes through the PCH at full rate.
- The block holds each byte stable on tx_data and pulses tx_send once per byte, pacing launches on the transmitter's busy flag.
- This frees software from polling UART_BUSY per byte; status (count/full/overflow) is readable back through the PCH.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- SEND_CYCLES, 2, width of the tx_send pulse in clocks; ≥1.
- BUSY_TIMEOUT, 64, clocks to wait for tx_busy to rise (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- wr_en  in  1  push wr_data this cycle (from the PCH enable_SendTx decode).
- wr_data  in  8  byte to queue (HWDATA_OUT[31:24]).
- clr_ovf  in  1  clear sticky overflow flag.
- tx_busy  in  1  transmitter busy (UART_BUSY).
- tx_send  out  1  launch strobe to the transmitter.
- tx_data  out  8  byte presented to the transmitter sw inputs.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky; a write was dropped.
- active  out  1  FSM not in IDLE.

Behaviour:
- Reset: every output is 0 except empty=1; pointers are 0; FSM=IDLE. Reset mid-transmission discards queued bytes and drops tx_send in the same cycle. The byte already in the UART is not recalled.
- FIFO storage:
  - Registered array; read pointer and write pointer are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate register, updated +1 on push only, -1 on pop only, unchanged on both or neither.
- Push: wr_en && !full writes at wr_ptr and increments it.
- Full write: wr_en && full drops the byte, sets overflow, and leaves pointers and count unchanged.
- Pop on a full FIFO: when wr_en coincides with a pop in the same cycle, the push is accepted; count stays DEPTH.
- Overflow flag: clr_ovf clears it. If clr_ovf coincides with a dropped write, overflow ends at 1 (set wins).
- FSM states:
  - IDLE: if !empty && !tx_busy, pop the head into tx_data register → SEND. Latency from the first push into an empty FIFO to tx_send=1 is 2 clocks.
  - SEND: tx_send=1 for exactly SEND_CYCLES clocks (down-counter) → WAIT_RISE. tx_data stays constant until the next pop.
  - WAIT_RISE: stay until tx_busy=1 → WAIT_FALL.
  - WAIT_FALL: stay until tx_busy=0 → IDLE. A back-to-back byte launches on the following cycle.
- tx_data holds the last launched byte while idle, and is never updated outside the IDLE→SEND pop.
- active = (state != IDLE).
- No push data is forwarded combinationally; the minimum FIFO residency is 1 clock.

Optional Feature:
- Macro: UART_TX_BUFFER_TIMEOUT_EN.
- Defined:
  - WAIT_RISE counts clocks. If tx_busy has not risen after BUSY_TIMEOUT clocks, the FSM returns to SEND and re-pulses the same tx_data (byte not lost), at most once.
  - On a second timeout the FSM goes to IDLE and the byte is discarded.
  - Adds output port timeout_err (1 bit, sticky, cleared by clr_ovf, reset 0).
- Undefined: WAIT_RISE waits indefinitely; no counter and no timeout_err port.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams S_IDLE=0, S_SEND=1, S_WAIT_RISE=2, S_WAIT_FALL=3.
  - UART_BYTE_W=8.
  - Default DEPTH and SEND_CYCLES.
- One natural sub-module, sync_fifo (parameterised width/depth, push/pop/count/full/empty). The launch FSM and overflow/timeout logic stay in uart_tx_buffer.

Test Plan:
- Reset, then push 0xA5 with tx_busy=0 → tx_send high on cycles 2–3 after the push, tx_data=0xA5. After the busy model raises then drops tx_busy, count returns to 0 and empty=1.
- Push 0x01..0x10 (DEPTH=16) with tx_busy held 1 → full=1, count=16. A 17th push of 0x55 sets overflow and count stays 16. Releasing busy then sends 0x01..0x10 in order and never 0x55.
- FIFO full, pop coincides with push of 0x77 → count stays 16 and 0x77 is transmitted last.
- clr_ovf and an overflowing push in the same cycle → overflow=1 afterwards. A later clr_ovf alone → overflow=0.
- Assert reset during WAIT_FALL with 3 bytes queued → next cycle: count=0, tx_send=0, active=0. A new push of 0x3C is sent correctly.
- With UART_TX_BUFFER_TIMEOUT_EN, tx_busy stuck 0 after a push of 0x99 → tx_send pulses twice, 64 clocks apart. After the second timeout the FSM returns to IDLE with timeout_err=1, and the next queued byte is still sent.
